// File: rtl/mimo_qpsk_modulator_if.sv
// Bit-stream, R-load and y_hat/trigger bundle of the 4x4 MIMO QPSK modulator.
// MLMOD_BITPASS_EN adds o_bits, the source byte of each o_y_hat.
interface mimo_qpsk_modulator_if;
    logic         i_bit;
    logic         i_bit_vld;
    logic         o_bit_rdy;
    logic         i_r_load;
    logic [319:0] i_r;
    logic         o_trig;
    logic [159:0] o_y_hat;
`ifdef MLMOD_BITPASS_EN
    logic [7:0]   o_bits;
`endif

    modport master (
        output i_bit, i_bit_vld, i_r_load, i_r,
`ifdef MLMOD_BITPASS_EN
        input  o_bits,
`endif
        input  o_bit_rdy, o_trig, o_y_hat
    );

    modport slave (
        input  i_bit, i_bit_vld, i_r_load, i_r,
`ifdef MLMOD_BITPASS_EN
        output o_bits,
`endif
        output o_bit_rdy, o_trig, o_y_hat
    );
endinterface

// File: rtl/mimo_qpsk_modulator.sv
// 4x4 QPSK modulator: packs bits into bytes, computes y_hat = R*x and paces
// o_trig pulses at least MIN_GAP cycles apart. MLMOD_BITPASS_EN adds o_bits.
module mimo_qpsk_modulator #(
    parameter int MIN_GAP = 64,
    parameter int SYM_AMP = 181
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    mimo_qpsk_modulator_if.slave  bus
);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam int ROW [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    localparam int COL [10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT, S_FIRE} state_e;

    state_e         state_q, state_d;
    logic [319:0]   r_q;
    logic [7:0]     col_q;
    logic [2:0]     cnt_q;
    logic           col_full_q;
    logic [7:0]     pend_q;
    logic           pend_vld_q;
    logic [GW-1:0]  gap_q, gap_d;
    logic [159:0]   y_stage_q, y_hat_q, y_calc;
`ifdef MLMOD_BITPASS_EN
    logic [7:0]     bits_q;
`endif

    logic fire, calc;
    logic accept, byte_done, slot_free, pend_load, gap_ok;
    logic [7:0] new_byte;

    assign accept    = bus.i_bit_vld && !col_full_q;
    assign byte_done = accept && (cnt_q == 3'd7);
    assign new_byte  = {bus.i_bit, col_q[6:0]};
    assign slot_free = !pend_vld_q || fire;
    assign pend_load = (col_full_q && fire) || (byte_done && slot_free);
    assign gap_ok    = (gap_q >= GW'(MIN_GAP - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pend_load) state_d = S_CALC;
            S_CALC:  state_d = gap_ok ? S_FIRE : S_WAIT;
            S_WAIT:  if (gap_ok) state_d = S_FIRE;
            S_FIRE:  state_d = pend_load ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fire = (state_q == S_FIRE);
        calc = (state_q == S_CALC);
    end

    // Gap counter reads 0 during a FIRE cycle, so it equals cycles since the last pulse.
    always_comb begin
        gap_d = gap_q;
        if (state_d == S_FIRE)           gap_d = '0;
        else if (gap_q != GW'(MIN_GAP))  gap_d = gap_q + GW'(1);
    end

    // Per-entry term R_kj * x_j with x components in {+1,-1}: add/sub only.
    logic signed [17:0] t_re [10];
    logic signed [17:0] t_im [10];

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_term
            logic signed [17:0] rr, ri;
            logic a_neg, b_neg;
            assign rr    = {{2{r_q[32*gi+31]}}, r_q[32*gi+16 +: 16]};
            assign ri    = {{2{r_q[32*gi+15]}}, r_q[32*gi +: 16]};
            assign a_neg = pend_q[2*COL[gi]];
            assign b_neg = pend_q[2*COL[gi]+1];
            assign t_re[gi] = (a_neg ? -rr : rr) + (b_neg ? ri : -ri);
            assign t_im[gi] = (b_neg ? -rr : rr) + (a_neg ? -ri : ri);
        end

        for (gi = 0; gi < 4; gi++) begin : g_row
            logic signed [18:0] acc_re, acc_im;
            logic signed [27:0] p_re, p_im;
            always_comb begin
                acc_re = '0;
                acc_im = '0;
                for (int n = 0; n < 10; n++) begin
                    if (ROW[n] == gi) begin
                        acc_re = acc_re + 19'(t_re[n]);
                        acc_im = acc_im + 19'(t_im[n]);
                    end
                end
            end
            assign p_re = 28'(acc_re) * 28'(SYM_AMP);
            assign p_im = 28'(acc_im) * 28'(SYM_AMP);
            assign y_calc[40*gi +: 40] = {20'(p_re >>> 8), 20'(p_im >>> 8)};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q        <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            col_full_q <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            gap_q      <= GW'(MIN_GAP);
            y_stage_q  <= '0;
            y_hat_q    <= '0;
`ifdef MLMOD_BITPASS_EN
            bits_q     <= '0;
`endif
        end else begin
            gap_q <= gap_d;
            if (bus.i_r_load) r_q <= bus.i_r;
            if (accept) begin
                col_q[cnt_q] <= bus.i_bit;
                cnt_q        <= cnt_q + 3'd1;
            end
            if (byte_done && slot_free) pend_q <= new_byte;
            else if (byte_done)         col_full_q <= 1'b1;
            if (col_full_q && fire) begin
                pend_q     <= col_q;
                col_full_q <= 1'b0;
            end
            if (pend_load)  pend_vld_q <= 1'b1;
            else if (fire)  pend_vld_q <= 1'b0;
            if (calc) y_stage_q <= y_calc;
            if (state_d == S_FIRE) begin
                y_hat_q <= calc ? y_calc : y_stage_q;
`ifdef MLMOD_BITPASS_EN
                bits_q  <= pend_q;
`endif
            end
        end
    end

    assign bus.o_bit_rdy = !col_full_q;
    assign bus.o_trig    = fire;
    assign bus.o_y_hat   = y_hat_q;
`ifdef MLMOD_BITPASS_EN
    assign bus.o_bits    = bits_q;
`endif

endmodule

// File: tb/tb_mimo_qpsk_modulator.sv
// Scoreboard bench for mimo_qpsk_modulator: a matrix-level model predicts each
// y_hat when its byte completes; a monitor checks every o_trig against it.
module tb_mimo_qpsk_modulator;
    localparam int MIN_GAP = 64;
    localparam int SYM_AMP = 181;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    mimo_qpsk_modulator_if bus ();

    mimo_qpsk_modulator #(.MIN_GAP(MIN_GAP), .SYM_AMP(SYM_AMP)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [159:0] y;
        logic [7:0]   by;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   trig_times[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_trig   = 0;
    int   last_trig;
    bit   have_last = 0;

    int   rre [4][4];
    int   rim [4][4];
    logic [7:0] shadow;
    int   nbits = 0;

    task automatic chk(input bit ok, input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // y_k = floor(SYM_AMP * sum_{j>=k} R_kj * x_j / 256), x = (1-2*bit) per component.
    function automatic logic [159:0] model_y(input logic [7:0] by);
        logic [159:0] y;
        int sre, sim, a, b;
        y = '0;
        for (int k = 0; k < 4; k++) begin
            sre = 0;
            sim = 0;
            for (int j = k; j < 4; j++) begin
                a = by[2*j]   ? -1 : 1;
                b = by[2*j+1] ? -1 : 1;
                sre += rre[k][j] * a - rim[k][j] * b;
                sim += rre[k][j] * b + rim[k][j] * a;
            end
            y[40*k+20 +: 20] = 20'((sre * SYM_AMP) >>> 8);
            y[40*k    +: 20] = 20'((sim * SYM_AMP) >>> 8);
        end
        return y;
    endfunction

    function automatic logic [319:0] build_r();
        logic [319:0] v;
        int n;
        v = '0;
        n = 0;
        for (int k = 0; k < 4; k++)
            for (int j = k; j < 4; j++) begin
                v[32*n +: 32] = {16'(rre[k][j]), 16'(rim[k][j])};
                n++;
            end
        return v;
    endfunction

    task automatic r_zero();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) begin
                rre[k][j] = 0;
                rim[k][j] = 0;
            end
    endtask

    task automatic load_r();
        @(negedge clk);
        bus.i_bit_vld = 1'b0;
        bus.i_r       = build_r();
        bus.i_r_load  = 1'b1;
        @(negedge clk);
        bus.i_r_load  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_bit_vld = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input bit lat);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        bus.i_bit     = b;
        bus.i_bit_vld = 1'b1;
        while (!bus.o_bit_rdy && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) begin
            chk(1'b0, "bit_rdy_timeout", 160'(w), 160'(0));
            return;
        end
        shadow[nbits] = b;
        nbits++;
        if (nbits == 8) begin
            nbits = 0;
            e.y   = model_y(shadow);
            e.by  = shadow;
            e.cyc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] by, input bit lat, input bit jitter);
        for (int i = 0; i < 8; i++) begin
            if (jitter && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_bit(by[i], lat);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk(sb.size() == 0, "drain", 160'(sb.size()), 160'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            have_last = 0;
        end else if (bus.o_trig) begin
            n_trig++;
            trig_times.push_back(cyc);
            $display("trig %0d cyc %0d y_hat=%h", n_trig, cyc, bus.o_y_hat);
            if (have_last)
                chk((cyc - last_trig) >= MIN_GAP, "trig_spacing", 160'(cyc - last_trig), 160'(MIN_GAP));
            have_last = 1;
            last_trig = cyc;
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_trig", 160'(cyc), 160'(0));
            end else begin
                e = sb.pop_front();
                chk(bus.o_y_hat == e.y, "y_hat", bus.o_y_hat, e.y);
`ifdef MLMOD_BITPASS_EN
                chk(bus.o_bits == e.by, "o_bits", 160'(bus.o_bits), 160'(e.by));
`endif
                if (e.lat)
                    chk(cyc == e.cyc + 2, "latency", 160'(cyc - e.cyc), 160'(2));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.i_bit     = 1'b0;
        bus.i_bit_vld = 1'b0;
        bus.i_r_load  = 1'b0;
        bus.i_r       = '0;
        shadow        = '0;
        r_zero();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(bus.o_trig == 1'b0, "reset_trig", 160'(bus.o_trig), 160'(0));
        chk(bus.o_y_hat == '0, "reset_y_hat", bus.o_y_hat, '0);
        chk(bus.o_bit_rdy == 1'b1, "reset_bit_rdy", 160'(bus.o_bit_rdy), 160'(1));

        // Identity R with the three directed bit patterns.
        for (int k = 0; k < 4; k++) rre[k][k] = 16384;
        load_r();
        send_byte(8'h00, 1'b1, 1'b0); idle(80);
        send_byte(8'hFF, 1'b1, 1'b0); idle(80);
        send_byte(8'h55, 1'b1, 1'b0); idle(80);

        // Full upper-triangular R, all re = 0x4000.
        for (int k = 0; k < 4; k++)
            for (int j = k; j < 4; j++) rre[k][j] = 16384;
        load_r();
        send_byte(8'h00, 1'b1, 1'b0); idle(80);
        drain();

        // Back-to-back: 24 contiguous bits, three pulses exactly MIN_GAP apart.
        trig_times.delete();
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'hA7, 1'b0, 1'b0);
        send_byte(8'h19, 1'b0, 1'b0);
        idle(250);
        chk(trig_times.size() == 3, "b2b_count", 160'(trig_times.size()), 160'(3));
        if (trig_times.size() == 3) begin
            chk(trig_times[1] - trig_times[0] == MIN_GAP, "b2b_gap1", 160'(trig_times[1] - trig_times[0]), 160'(MIN_GAP));
            chk(trig_times[2] - trig_times[1] == MIN_GAP, "b2b_gap2", 160'(trig_times[2] - trig_times[1]), 160'(MIN_GAP));
        end
        drain();

        // R load coinciding with CALC: that byte sees old R, the next one new R.
        send_byte(8'h6B, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            for (int j = k; j < 4; j++) begin
                rre[k][j] = 1000 * (k + 1) - 700 * j;
                rim[k][j] = 300 * j - 500 * k + 11;
            end
        @(negedge clk);
        bus.i_bit_vld = 1'b0;
        bus.i_r       = build_r();
        bus.i_r_load  = 1'b1;
        @(negedge clk);
        bus.i_r_load  = 1'b0;
        idle(80);
        send_byte(8'h6B, 1'b1, 1'b0);
        idle(80);
        drain();

        // Reset after 5 bits: partial byte dropped, R and y_hat cleared.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        bus.i_bit_vld = 1'b0;
        rst_n = 1'b0;
        nbits = 0;
        sb.delete();
        r_zero();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        chk(bus.o_y_hat == '0, "post_reset_y_hat", bus.o_y_hat, '0);
        chk(bus.o_bit_rdy == 1'b1, "post_reset_bit_rdy", 160'(bus.o_bit_rdy), 160'(1));
        for (int k = 0; k < 4; k++) rre[k][k] = 16384;
        load_r();
        send_byte(8'hC3, 1'b1, 1'b0);
        idle(80);
        drain();

        // Random R (avoiding -32768) and random bytes with bit and byte jitter.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++)
                for (int j = k; j < 4; j++) begin
                    rre[k][j] = int'($urandom_range(0, 65534)) - 32767;
                    rim[k][j] = int'($urandom_range(0, 65534)) - 32767;
                end
            load_r();
            for (int i = 0; i < 5; i++) begin
                send_byte(8'($urandom), 1'b0, 1'b1);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 100));
            end
            drain();
            idle(70);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
